// File: rtl/db15_serial_rx.sv
// db15_serial_rx
//   Reads the DB15 user-port joystick adapter. Each frame pulses the
//   adapter's parallel load, clocks 32 bits out of its shift-register chain,
//   and presents two active-high 16-bit joystick words, then idles for a gap.
//
//   Parameters:
//     CLK_DIV    system clocks per bit-tick (4..255)
//     GAP_TICKS  idle ticks between frames (1..255)
//
//   Ports:
//     CLK         system clock
//     RESET       asynchronous, active-high reset
//     JOY_DATA    serial data from the adapter (active-low buttons, async)
//     JOY_CLK     shift clock to the adapter
//     JOY_LOAD    parallel load to the adapter, active-low
//     joystick1   player 1 buttons, active-high (LS FEDCBA UDLR, bit 11..0)
//     joystick2   player 2 buttons, active-high, same order
//     frame_done  one-CLK pulse when a frame completes
//
//   Build option:
//     DB15_DEBOUNCE_EN  when defined, a frame is committed to the outputs
//                       only if it matches the previous frame's raw word.

module db15_serial_rx #(
    parameter int CLK_DIV   = 8,
    parameter int GAP_TICKS = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        frame_done
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE,
        S_GAP
    } state_t;

    state_t      state;
    logic [7:0]  div_cnt;
    logic        tick;
    logic [1:0]  sync_ff;
    logic        sdata;
    logic [4:0]  bit_cnt;
    logic [31:0] raw;
    logic [7:0]  gap_cnt;
`ifdef DB15_DEBOUNCE_EN
    logic [31:0] prev_raw;
`endif

    assign tick  = (div_cnt == DIV_LAST);
    assign sdata = sync_ff[1];

    // JOY_DATA is asynchronous to CLK; idle level of the line is 1.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_ff <= 2'b11;
        end else begin
            sync_ff <= {sync_ff[0], JOY_DATA};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_LOAD;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            raw        <= '1;
            gap_cnt    <= '0;
            joystick1  <= '0;
            joystick2  <= '0;
            JOY_LOAD   <= 1'b1;
            JOY_CLK    <= 1'b0;
            frame_done <= 1'b0;
`ifdef DB15_DEBOUNCE_EN
            prev_raw   <= '1;
`endif
        end else begin
            // Adapter pins are registered copies of the state, one CLK
            // behind it; every phase therefore keeps its full length and
            // the data sample lands CLK_DIV-1 cycles after JOY_CLK falls.
            JOY_LOAD   <= (state != S_LOAD);
            JOY_CLK    <= (state == S_SHIFT_HI);
            frame_done <= (state == S_DONE);

            // DONE is a single CLK outside the tick grid, so the divider
            // pauses there.
            if (state != S_DONE) begin
                div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
            end

            case (state)
                S_LOAD: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        state   <= S_SHIFT_LO;
                    end
                end
                S_SHIFT_LO: begin
                    if (tick) begin
                        raw[bit_cnt] <= sdata;
                        state        <= S_SHIFT_HI;
                    end
                end
                S_SHIFT_HI: begin
                    if (tick) begin
                        if (bit_cnt == 5'd31) begin
                            state <= S_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            state   <= S_SHIFT_LO;
                        end
                    end
                end
                S_DONE: begin
`ifdef DB15_DEBOUNCE_EN
                    if (raw == prev_raw) begin
                        joystick1 <= ~raw[15:0];
                        joystick2 <= ~raw[31:16];
                    end
                    prev_raw <= raw;
`else
                    joystick1 <= ~raw[15:0];
                    joystick2 <= ~raw[31:16];
`endif
                    gap_cnt <= '0;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= S_LOAD;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_db15_serial_rx.sv
// Bench for db15_serial_rx: a word-level 74165 chain model drives JOY_DATA,
// and a reference computes the committed joystick words frame by frame.
module tb_db15_serial_rx;

    localparam int CLK_DIV    = 4;
    localparam int GAP_TICKS  = 8;
    localparam int FRAME_CLKS = (1 + 64 + GAP_TICKS) * CLK_DIV + 1; // 293
    localparam int DONE_CYC   = (1 + 64) * CLK_DIV + 1;             // 261

    logic        CLK   = 1'b0;
    logic        RESET = 1'b0;
    logic        JOY_DATA;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic        frame_done;
    logic [15:0] joystick1;
    logic [15:0] joystick2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Adapter model: parallel word latched on load, one bit out per
    // rising JOY_CLK, bit 0 first; serial-in tied high.
    logic [31:0] model_word = '1;
    logic [31:0] latched    = '1;
    int          sh_cnt     = 32;
    logic [31:0] load_q[$];

    // Reference state: last word committed to the outputs and previous frame.
    logic [31:0] ref_prev      = '1;
    logic [31:0] ref_committed = '1;

    db15_serial_rx #(
        .CLK_DIV   (CLK_DIV),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .JOY_DATA   (JOY_DATA),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .frame_done (frame_done)
    );

    always #5 CLK = ~CLK;

    // cyc == k during the k-th CLK period after reset release
    always @(posedge CLK or posedge RESET) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge JOY_LOAD or posedge JOY_CLK) begin
        if (!JOY_LOAD) begin
            latched = model_word;
            sh_cnt  = 0;
            load_q.push_back(model_word);
        end else if (sh_cnt < 32) begin
            sh_cnt = sh_cnt + 1;
        end
    end

    assign JOY_DATA = (sh_cnt < 32) ? latched[sh_cnt[4:0]] : 1'b1;

    task automatic reset_model();
        load_q.delete();
        ref_prev      = '1;
        ref_committed = '1;
    endtask

    // Expected outputs after the oldest loaded frame completes.
    task automatic ref_frame(output logic [15:0] e1, output logic [15:0] e2);
        logic [31:0] w;
        w = '1;
        if (load_q.size() != 0) w = load_q.pop_front();
`ifdef DB15_DEBOUNCE_EN
        if (w == ref_prev) ref_committed = w;
        ref_prev = w;
`else
        ref_committed = w;
`endif
        e1 = ~ref_committed[15:0];
        e2 = ~ref_committed[31:16];
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1'b1;
        reset_model();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b1;
        reset_model();
        #1;
        checks++;
        if ({joystick1, joystick2, JOY_LOAD, JOY_CLK, frame_done} !== {16'h0, 16'h0, 3'b100}) begin
            errors++;
            $display("FAIL reset_async: got j1=%h j2=%h load=%b clk=%b done=%b, expected 0000 0000 1 0 0",
                     joystick1, joystick2, JOY_LOAD, JOY_CLK, frame_done);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if ({joystick1, joystick2, JOY_LOAD, JOY_CLK, frame_done} !== {16'h0, 16'h0, 3'b100}) begin
            errors++;
            $display("FAIL reset_held: got j1=%h j2=%h load=%b clk=%b done=%b, expected 0000 0000 1 0 0",
                     joystick1, joystick2, JOY_LOAD, JOY_CLK, frame_done);
        end
        RESET = 1'b0;
    endtask

    task automatic test_idle_frame();
        int          load_first = -1;
        int          load_len   = 0;
        int          pulses     = 0;
        int          bad_w      = 0;
        int          cur_w      = 0;
        int          done_at    = -1;
        logic        prev_clk   = 1'b0;
        logic [15:0] s1 = 16'hDEAD;
        logic [15:0] s2 = 16'hBEEF;
        logic [15:0] e1, e2;
        model_word = '1;
        apply_reset();
        for (int i = 0; i < DONE_CYC + 8; i++) begin
            @(negedge CLK);
            if (!JOY_LOAD) begin
                if (load_first < 0) load_first = cyc;
                load_len++;
            end
            if (JOY_CLK) begin
                if (!prev_clk) begin
                    pulses++;
                    cur_w = 0;
                end
                cur_w++;
            end else if (prev_clk && cur_w != CLK_DIV) begin
                bad_w++;
            end
            prev_clk = JOY_CLK;
            if (frame_done && done_at < 0) begin
                done_at = cyc;
                s1 = joystick1;
                s2 = joystick2;
            end
        end
        checks++;
        if (load_first != 1) begin
            errors++;
            $display("FAIL idle_load_start: got cycle %0d, expected 1", load_first);
        end
        checks++;
        if (load_len != CLK_DIV) begin
            errors++;
            $display("FAIL idle_load_width: got %0d, expected %0d", load_len, CLK_DIV);
        end
        checks++;
        if (pulses != 32) begin
            errors++;
            $display("FAIL idle_clk_pulses: got %0d, expected 32", pulses);
        end
        checks++;
        if (bad_w != 0) begin
            errors++;
            $display("FAIL idle_clk_width: got %0d pulses not %0d wide, expected 0", bad_w, CLK_DIV);
        end
        checks++;
        if (done_at != DONE_CYC) begin
            errors++;
            $display("FAIL idle_done_cycle: got %0d, expected %0d", done_at, DONE_CYC);
        end
        ref_frame(e1, e2);
        checks++;
        if ({s1, s2} !== {e1, e2}) begin
            errors++;
            $display("FAIL idle_outputs: got %h %h, expected %h %h", s1, s2, e1, e2);
        end
    endtask

    task automatic test_pattern();
        bit          seen;
        logic [15:0] e1, e2;
        model_word = 32'hFFFE_FFEF;
        apply_reset();
        wait_done(FRAME_CLKS + 20, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL pattern_timeout: got no frame_done, expected one");
        end
        ref_frame(e1, e2);
        checks++;
        if ({joystick1, joystick2} !== {e1, e2}) begin
            errors++;
            $display("FAIL pattern_outputs: got %h %h, expected %h %h", joystick1, joystick2, e1, e2);
        end
    endtask

    task automatic test_periodicity();
        int          done_c[2] = '{0, 0};
        int          load_c[2] = '{0, 0};
        int          nd = 0;
        int          nl = 0;
        logic        prev_load;
        logic [15:0] e1, e2;
        model_word = $urandom;
        prev_load  = JOY_LOAD;
        for (int i = 0; i < 2 * FRAME_CLKS + 40 && nd < 2; i++) begin
            @(negedge CLK);
            if (prev_load && !JOY_LOAD && nl < 2) begin
                load_c[nl] = cyc;
                nl++;
            end
            prev_load = JOY_LOAD;
            if (frame_done) begin
                done_c[nd] = cyc;
                nd++;
                ref_frame(e1, e2);
                checks++;
                if ({joystick1, joystick2} !== {e1, e2}) begin
                    errors++;
                    $display("FAIL period_outputs: got %h %h, expected %h %h", joystick1, joystick2, e1, e2);
                end
            end
        end
        checks++;
        if (nd != 2 || done_c[1] - done_c[0] != FRAME_CLKS) begin
            errors++;
            $display("FAIL period_done: got %0d pulses spaced %0d, expected 2 spaced %0d",
                     nd, done_c[1] - done_c[0], FRAME_CLKS);
        end
        checks++;
        if (nl != 2 || load_c[1] - load_c[0] != FRAME_CLKS) begin
            errors++;
            $display("FAIL period_load: got %0d loads spaced %0d, expected 2 spaced %0d",
                     nl, load_c[1] - load_c[0], FRAME_CLKS);
        end
    endtask

    task automatic test_midshift();
        logic [31:0] a, b;
        logic [15:0] e1, e2, o1, o2;
        bit          seen;
        int          changes = 0;
        a = $urandom;
        b = ~a;
        model_word = a;
        for (int f = 0; f < 2; f++) begin
            wait_done(FRAME_CLKS + 20, seen);
            ref_frame(e1, e2);
            checks++;
            if (!seen || {joystick1, joystick2} !== {e1, e2}) begin
                errors++;
                $display("FAIL midshift_pre%0d: got %h %h seen=%0d, expected %h %h seen=1",
                         f, joystick1, joystick2, seen, e1, e2);
            end
        end
        // land in SHIFT_HI of bit 10 of the next frame
        repeat (FRAME_CLKS + (2 + 2 * 10) * CLK_DIV + 1 - DONE_CYC) @(negedge CLK);
        model_word = b;
        o1 = ~ref_committed[15:0];
        o2 = ~ref_committed[31:16];
        seen = 1'b0;
        for (int i = 0; i < FRAME_CLKS; i++) begin
            @(negedge CLK);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
            if ({joystick1, joystick2} !== {o1, o2}) changes++;
        end
        checks++;
        if (!seen || changes != 0) begin
            errors++;
            $display("FAIL midshift_hold: got %0d early changes seen=%0d, expected 0 seen=1", changes, seen);
        end
        ref_frame(e1, e2);
        checks++;
        if ({joystick1, joystick2} !== {e1, e2}) begin
            errors++;
            $display("FAIL midshift_old: got %h %h, expected %h %h", joystick1, joystick2, e1, e2);
        end
        wait_done(FRAME_CLKS + 20, seen);
        ref_frame(e1, e2);
        checks++;
        if (!seen || {joystick1, joystick2} !== {e1, e2}) begin
            errors++;
            $display("FAIL midshift_new: got %h %h seen=%0d, expected %h %h seen=1",
                     joystick1, joystick2, seen, e1, e2);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] e1, e2;
        bit          seen;
        int          load_first = -1;
        int          done_at    = -1;
        logic [15:0] s1 = 16'hDEAD;
        logic [15:0] s2 = 16'hBEEF;
        model_word = $urandom & 32'hFFFF_FFFE;
        for (int f = 0; f < 2; f++) begin
            wait_done(FRAME_CLKS + 20, seen);
            ref_frame(e1, e2);
        end
        // land in the first cycle of SHIFT_LO of bit 20 of the next frame
        repeat (FRAME_CLKS + (1 + 2 * 20) * CLK_DIV - DONE_CYC) @(negedge CLK);
        #1;
        RESET = 1'b1;
        reset_model();
        #1;
        checks++;
        if ({joystick1, joystick2, JOY_LOAD, JOY_CLK, frame_done} !== {16'h0, 16'h0, 3'b100}) begin
            errors++;
            $display("FAIL reset_mid_async: got j1=%h j2=%h load=%b clk=%b done=%b, expected 0000 0000 1 0 0",
                     joystick1, joystick2, JOY_LOAD, JOY_CLK, frame_done);
        end
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < DONE_CYC + 4; i++) begin
            @(negedge CLK);
            if (!JOY_LOAD && load_first < 0) load_first = cyc;
            if (frame_done && done_at < 0) begin
                done_at = cyc;
                s1 = joystick1;
                s2 = joystick2;
            end
        end
        checks++;
        if (load_first != 1 || done_at != DONE_CYC) begin
            errors++;
            $display("FAIL reset_mid_restart: got load at %0d done at %0d, expected 1 and %0d",
                     load_first, done_at, DONE_CYC);
        end
        ref_frame(e1, e2);
        checks++;
        if ({s1, s2} !== {e1, e2}) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h %h, expected %h %h", s1, s2, e1, e2);
        end
    endtask

    task automatic test_random();
        logic [15:0] e1, e2;
        bit          seen;
        for (int f = 0; f < 8; f++) begin
            // repeat a word now and then so back-to-back equal frames occur
            if ($urandom_range(0, 2) != 0) model_word = $urandom;
            wait_done(FRAME_CLKS + 20, seen);
            ref_frame(e1, e2);
            checks++;
            if (!seen || {joystick1, joystick2} !== {e1, e2}) begin
                errors++;
                $display("FAIL random_frame%0d: got %h %h seen=%0d, expected %h %h seen=1",
                         f, joystick1, joystick2, seen, e1, e2);
            end
        end
    endtask

`ifdef DB15_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] words[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [15:0] exp1[6]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001};
        logic [15:0] e1, e2;
        bit          seen;
        model_word = words[0];
        apply_reset();
        for (int f = 0; f < 6; f++) begin
            wait_done(FRAME_CLKS + 20, seen);
            ref_frame(e1, e2);
            if (f < 5) model_word = words[f + 1];
            checks++;
            if (!seen || joystick1 !== exp1[f]) begin
                errors++;
                $display("FAIL debounce_frame%0d: got %h seen=%0d, expected %h seen=1",
                         f, joystick1, seen, exp1[f]);
            end
        end
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_idle_frame();
        test_pattern();
        test_periodicity();
        test_midshift();
        test_reset_midframe();
        test_random();
`ifdef DB15_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
